// File: rtl/counter_pkg.sv
// Shared constants and types for the command-driven 8-bit counter sequencer.
package counter_pkg;

  localparam int CNT_W = 8;

  typedef logic [1:0] op_t;

  localparam op_t OP_CLEAR = 2'b00;
  localparam op_t OP_LOAD  = 2'b01;
  localparam op_t OP_RUN   = 2'b10;
  localparam op_t OP_READ  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // A RUN leaves EXEC on the cycle that consumes the last increment,
  // or immediately when N was zero.
  function automatic logic run_last(input logic [CNT_W-1:0] rem);
    return (rem <= 1);
  endfunction

endpackage

// File: rtl/counter_8_bit.sv
// 8-bit programmable counter: synchronous reset, parallel load, else increment.
module counter_8_bit
  import counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             out_e,
  input  logic             load_e,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] out_data
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)         cnt <= '0;
    else if (load_e) cnt <= load_val;
    else             cnt <= cnt + 1'b1;
  end

  assign out_data = out_e ? cnt : '0;

endmodule

// File: rtl/counter_cmd_ctrl.sv
// Command sequencer around counter_8_bit: accepts CLEAR/LOAD/RUN/READ and
// returns one response per command carrying the resulting count.
module counter_cmd_ctrl
  import counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] rsp_data,
  output logic             busy
);

  state_t           state, state_nxt;
  op_t              op_q;
  logic [CNT_W-1:0] arg_q;
  logic [CNT_W-1:0] rem_q, rem_nxt;

  logic             cnt_rst;
  logic             cnt_clr;
  logic             load_e;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] out_data;
  logic             accept;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_data  = rsp_valid ? out_data : '0;
  assign cnt_rst   = rst || cnt_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= OP_CLEAR;
      arg_q <= '0;
      rem_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q  <= op_t'(cmd_op);
        arg_q <= cmd_arg;
        rem_q <= (op_t'(cmd_op) == OP_RUN) ? cmd_arg : '0;
      end else begin
        rem_q <= rem_nxt;
      end
    end
  end

  // Default is freeze: reload the live count so the counter never free-runs.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem_q;
    load_e    = 1'b1;
    load_val  = out_data;
    cnt_clr   = 1'b0;
    unique case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: begin
        unique case (op_q)
          OP_CLEAR: begin
            cnt_clr   = 1'b1;
            state_nxt = RESP;
          end
          OP_LOAD: begin
            load_val  = arg_q;
            state_nxt = RESP;
          end
          OP_RUN: begin
            if (rem_q != '0) begin
              load_e  = 1'b0;
              rem_nxt = rem_q - 1'b1;
            end
            if (run_last(rem_q)) state_nxt = RESP;
          end
          default: state_nxt = RESP;
        endcase
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  counter_8_bit u_cnt (
    .clk     (clk),
    .rst     (cnt_rst),
    .out_e   (1'b1),
    .load_e  (load_e),
    .load_val(load_val),
    .out_data(out_data)
  );

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Randomized + directed bench for counter_cmd_ctrl against a transaction-timeline model.
module tb_counter_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_arg = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       busy;

  counter_cmd_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_arg  (cmd_arg),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Model: what the outputs must be right now, and the architectural count.
  logic       m_busy = 1'b0;
  logic       m_rv   = 1'b0;
  logic [7:0] m_resp = 8'h00;
  logic [7:0] m_cnt  = 8'h00;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmd_ready", {7'd0, cmd_ready}, {7'd0, !m_busy && !rst});
    chk("busy",      {7'd0, busy},      {7'd0, m_busy});
    chk("rsp_valid", {7'd0, rsp_valid}, {7'd0, m_rv});
    chk("rsp_data",  rsp_data,          m_rv ? m_resp : 8'h00);
  end

  // Issue one command, hold rsp_ready low for 'stall' cycles, then accept.
  // cmd_valid stays high with junk while busy; it must be ignored.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] arg,
                        input int stall, output logic [7:0] got);
    logic [7:0] exp;
    int k;
    cmd_op = op; cmd_arg = arg; cmd_valid = 1'b1;
    @(posedge clk); #1;
    m_busy  = 1'b1;
    cmd_op  = 2'($urandom);
    cmd_arg = 8'($urandom);
    case (op)
      2'd0:    exp = 8'h00;
      2'd1:    exp = arg;
      2'd2:    exp = m_cnt + arg;
      default: exp = m_cnt;
    endcase
    k = (op == 2'd2 && arg > 1) ? int'(arg) : 1;
    repeat (k) @(posedge clk);
    #1;
    m_rv = 1'b1; m_resp = exp; m_cnt = exp;
    got = rsp_data;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    m_rv = 1'b0; m_busy = 1'b0; m_resp = 8'h00;
  endtask

  task automatic reset_mid_run();
    cmd_op = 2'd2; cmd_arg = 8'd200; cmd_valid = 1'b1;
    @(posedge clk); #1;
    m_busy = 1'b1; cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; m_busy = 1'b0; m_rv = 1'b0;
    #1;
    chk("rst_async_busy",  {7'd0, busy},      8'h00);
    chk("rst_async_valid", {7'd0, rsp_valid}, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0; m_cnt = 8'h00;
  endtask

  initial begin
    logic [7:0] g;
    logic [1:0] op;
    logic [7:0] arg;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    do_cmd(2'd3, 8'h00, 0, g);  chk("read_after_reset", g, 8'h00);
    do_cmd(2'd1, 8'hA5, 0, g);  chk("load_a5", g, 8'hA5);
    repeat (20) @(posedge clk);
    #1;
    do_cmd(2'd3, 8'h00, 0, g);  chk("read_after_idle", g, 8'hA5);
    do_cmd(2'd1, 8'hFE, 0, g);  chk("load_fe", g, 8'hFE);
    do_cmd(2'd2, 8'd3, 0, g);   chk("run3_wrap", g, 8'h01);
    do_cmd(2'd1, 8'h10, 1, g);  chk("load_10", g, 8'h10);
    do_cmd(2'd2, 8'd0, 0, g);   chk("run0", g, 8'h10);
    do_cmd(2'd0, 8'h77, 0, g);  chk("clear", g, 8'h00);
    do_cmd(2'd2, 8'd255, 0, g); chk("run255", g, 8'hFF);
    do_cmd(2'd2, 8'd5, 10, g);  chk("run5_backpressure", g, 8'h04);
    do_cmd(2'd3, 8'h00, 0, g);  chk("read_after_bp", g, 8'h04);
    reset_mid_run();
    do_cmd(2'd3, 8'h00, 0, g);  chk("read_after_mid_rst", g, 8'h00);

    for (int i = 0; i < 80; i++) begin
      op  = 2'($urandom_range(0, 3));
      arg = (op == 2'd2) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      do_cmd(op, arg, $urandom_range(0, 3), g);
      chk("rand_rsp", g, m_cnt);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
